set_reset_sequencer: RTL
========================

// Module: set_reset_sequencer
// PURPOSE
//  Upstream control stage for set/reset flip-flop banks. Takes raw asynchronous
//  set and clear requests and synchronizes them. Arbitrates between them and
//  emits clean, mutually exclusive pulses: set_o (active-high), reset_n_o (active-low).
//  Every pulse has a fixed width and is followed by a guaranteed dead gap, so the
//  consuming flops never see set and reset asserted together.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth on set_req/clr_req (>=2)
//  PULSE_W      4  output pulse width in clk cycles (1..2**CNT_W)
//  GAP_W        2  dead cycles after each pulse before the next may start (1..2**CNT_W)
//  CNT_W        4  width of the internal down-counter
// PORTS
//  clk        in   1  single clock; all state on posedge
//  reset      in   1  synchronous, active-low reset
//  enable     in   1  1 = new pulses may start; 0 = hold off (pending kept)
//  set_req    in   1  async set request; rising edge = one request
//  clr_req    in   1  async clear request; rising edge = one request
//  ovf_clr    in   1  synchronous clear of ovf
//  set_o      out  1  set pulse to downstream flops, active-high
//  reset_n_o  out  1  reset pulse to downstream flops, active-low
//  busy       out  1  high in SET_P, CLR_P, GAP
//  ovf        out  1  sticky: a request was dropped
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE, counter=0, sync chains=0, edge regs=0, both pending flags=0.
//   - Outputs: set_o=0, reset_n_o=1, busy=0, ovf=0.
//   - Reset overrides everything, including a pulse in progress.
//  Input path:
//   - Each request passes through a SYNC_STAGES flop chain, then an edge-detect flop.
//   - A rising edge sets set_pend or clr_pend.
//   - Edge arriving while its pend flag is already 1: dropped, ovf<=1.
//   - ovf_clr=1 clears ovf; a same-cycle drop wins (ovf stays 1).
//  FSM states: IDLE, SET_P, CLR_P, GAP. All outputs are registered and driven from state.
//   IDLE:
//    - enable && set_pend -> SET_P; clear set_pend; cnt<=PULSE_W-1.
//    - else enable && clr_pend -> CLR_P; clear clr_pend; cnt<=PULSE_W-1.
//    - Set has priority. A clear pending at the same time is kept and served after GAP.
//   SET_P: set_o=1. cnt==0 -> GAP with cnt<=GAP_W-1; else cnt--.
//   CLR_P: reset_n_o=0. Same counting as SET_P.
//   GAP:
//    - Both outputs inactive. cnt==0 -> IDLE; else cnt--.
//    - GAP->IDLE->next pulse costs one IDLE cycle, so the minimum spacing is
//      PULSE_W+GAP_W+1 cycles.
//  Invariants:
//   - set_o==1 && reset_n_o==0 never occurs.
//   - Each pulse is exactly PULSE_W cycles.
//  Latency:
//   - Count edges from the first edge that samples req=1, with IDLE, enable=1, no pend.
//   - Pend is set at edge SYNC_STAGES+1; the output asserts at edge SYNC_STAGES+2.
//  enable:
//   - Only gates IDLE exits. A pulse or gap already in progress always completes.
//   - Requests keep arriving into pend while enable=0.
//  Requests arriving during SET_P/CLR_P/GAP pend normally (one deep per type).
// TESTING
//  - set_req 0->1 at edge 0 (defaults) -> set_o=1 at edges 4..7; busy=1 at edges 4..9; then IDLE.
//  - set_req and clr_req rise in the same cycle -> set_o 4 cycles, 2-cycle gap, 1 IDLE cycle,
//    then reset_n_o=0 for 4 cycles; the two are never overlapped.
//  - Three set_req edges during one pulse, spaced >=SYNC_STAGES+1 cycles -> 2nd pends,
//    3rd sets ovf=1; exactly two set pulses; ovf_clr -> ovf=0.
//  - enable=0 with clr_req edge -> no pulse for 20 cycles; enable=1 -> reset_n_o=0 on the next edge.
//  - reset=0 mid-SET_P (cnt=2) -> next edge set_o=0, busy=0, pend=0; no pulse after reset releases.
//  - Random req/enable/reset for 10k cycles -> assert mutual exclusion, exact widths, gap >= GAP_W.

Source files
------------

// File: rtl/set_reset_sequencer.sv
// rtl/set_reset_sequencer.sv - synchronized, arbitrated set/reset pulse generator with dead gap
module set_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 4,
    parameter int GAP_W       = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic set_req,
    input  logic clr_req,
    input  logic ovf_clr,
    output logic set_o,
    output logic reset_n_o,
    output logic busy,
    output logic ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Counter reload values; the counter runs down to zero inclusive.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

    logic [SYNC_STAGES-1:0] set_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic                   set_edge_q;
    logic                   clr_edge_q;
    logic                   set_rise;
    logic                   clr_rise;

    logic                   set_pend_q, set_pend_d;
    logic                   clr_pend_q, clr_pend_d;
    logic                   ovf_q, ovf_d;
    logic                   take_set;
    logic                   take_clr;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   set_q;
    logic                   rstn_q;
    logic                   busy_q;

    // Synchronizer chains and edge-detect registers for both raw requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            set_sync_q <= '0;
            clr_sync_q <= '0;
            set_edge_q <= 1'b0;
            clr_edge_q <= 1'b0;
        end else begin
            set_sync_q <= {set_sync_q[SYNC_STAGES-2:0], set_req};
            clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], clr_req};
            set_edge_q <= set_sync_q[SYNC_STAGES-1];
            clr_edge_q <= clr_sync_q[SYNC_STAGES-1];
        end
    end

    assign set_rise = set_sync_q[SYNC_STAGES-1] & ~set_edge_q;
    assign clr_rise = clr_sync_q[SYNC_STAGES-1] & ~clr_edge_q;

    // Pending flags are one deep; an edge that finds its flag already set is lost and flagged.
    always_comb begin
        set_pend_d = set_pend_q;
        clr_pend_d = clr_pend_q;
        ovf_d      = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (take_set) begin
            set_pend_d = 1'b0;
        end
        if (take_clr) begin
            clr_pend_d = 1'b0;
        end
        if (set_rise) begin
            if (set_pend_q) begin
                ovf_d = 1'b1;
            end else begin
                set_pend_d = 1'b1;
            end
        end
        if (clr_rise) begin
            if (clr_pend_q) begin
                ovf_d = 1'b1;
            end else begin
                clr_pend_d = 1'b1;
            end
        end
    end

    // Pending flags and sticky overflow register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            set_pend_q <= set_pend_d;
            clr_pend_q <= clr_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: set wins arbitration in IDLE; pulses and gaps always run to completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        take_set = 1'b0;
        take_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && set_pend_q) begin
                    state_d  = SET_P;
                    cnt_d    = PULSE_LOAD;
                    take_set = 1'b1;
                end else if (enable && clr_pend_q) begin
                    state_d  = CLR_P;
                    cnt_d    = PULSE_LOAD;
                    take_clr = 1'b1;
                end
            end
            SET_P, CLR_P: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            set_q   <= 1'b0;
            rstn_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= (state_d == SET_P);
            rstn_q  <= (state_d != CLR_P);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign set_o     = set_q;
    assign reset_n_o = rstn_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule
